// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling 8N1 serial receiver for the data-memory UART port.
// Samples UART_RX through a 2-flop synchronizer, deframes LSB-first characters
// and holds received bytes until the data memory pops them with RX_READ.
// Build option: define UART_RX_FIFO_EN to replace the single holding register
// with a 4-entry first-word-fall-through FIFO. Ports are identical in both builds.
module uart_rx #(
  parameter int unsigned CLK_DIV = 651  // sysclk cycles per oversample tick, 2..65535
) (
  input  logic       sysclk,
  input  logic       reset,        // synchronous, active-low
  input  logic       UART_RX,
  input  logic       RX_READ,
  output logic [7:0] UART_RXD,
  output logic       RX_EFF,
  output logic       RX_OVERRUN,
  output logic       RX_FRAME_ERR
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [15:0] div_q, div_d;
  logic [3:0]  os_q, os_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tick;
  logic        push;
  logic        frame_err_q, frame_err_d;
  logic        ovr_q, ovr_d;
  logic        ovr_evt;

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Oversample tick: the divider is parked at 0 while idle.
  always_comb begin
    tick = (state_q != S_IDLE) && (div_q == DIV_LAST);
  end

  // Frame FSM next-state: counts ticks to mid-bit sample points.
  // NOTE: every variable gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    os_d        = os_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = tick ? 16'd0 : div_q + 16'd1;
    end
    if (tick) begin
      os_d = os_q + 4'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        div_d = 16'd0;
        os_d  = 4'd0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          idx_d   = 3'd0;
        end
      end
      S_START: begin
        // Half a bit in: a line back high means the edge was a glitch.
        if (tick && os_q == 4'd7) begin
          os_d    = 4'd0;
          idx_d   = 3'd0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick && os_q == 4'd15) begin
          os_d    = 4'd0;
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leave at mid-stop so a following start edge is never missed.
        if (tick && os_q == 4'd15) begin
          os_d    = 4'd0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame FSM and shared flag registers.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      div_q       <= 16'd0;
      os_q        <= 4'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      frame_err_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      os_q        <= os_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      ovr_q       <= ovr_d;
    end
  end

  // Overrun is sticky; any read clears it unless a byte is dropped that cycle.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_evt) begin
      ovr_d = 1'b1;
    end else if (RX_READ) begin
      ovr_d = 1'b0;
    end
  end

  assign RX_OVERRUN   = ovr_q;
  assign RX_FRAME_ERR = frame_err_q;

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] cnt_q, cnt_d;
  logic       pop, push_ok;

  // FIFO control: a pop in the same cycle frees a slot for a push at count 4.
  always_comb begin
    pop     = RX_READ && (cnt_q != 3'd0);
    push_ok = push && ((cnt_q != 3'd4) || pop);
    ovr_evt = push && !push_ok;
    cnt_d   = cnt_q + {2'b00, push_ok} - {2'b00, pop};
  end

  // FIFO storage and pointers.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      // NOTE: the entries are reset because UART_RXD shows the head entry
      // directly and must read 0x00 out of reset.
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      cnt_q <= 3'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) begin
        rd_q <= rd_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end

  assign UART_RXD = mem_q[rd_q];
  assign RX_EFF   = (cnt_q != 3'd0);
`else
  logic [7:0] data_q, data_d;
  logic       eff_q, eff_d;
  logic       pop;

  // Holding register: pop is applied before push so a full store can refill.
  always_comb begin
    pop     = RX_READ && eff_q;
    data_d  = data_q;
    eff_d   = eff_q;
    ovr_evt = 1'b0;
    if (pop) begin
      eff_d = 1'b0;
    end
    if (push) begin
      if (!eff_q || pop) begin
        data_d = shift_q;
        eff_d  = 1'b1;
      end else begin
        ovr_evt = 1'b1;
      end
    end
  end

  // Holding register state; data is kept after a pop.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      data_q <= 8'd0;
      eff_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      eff_q  <= eff_d;
    end
  end

  assign UART_RXD = data_q;
  assign RX_EFF   = eff_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with CLK_DIV=4 (64 cycles/bit).
// Inputs change on the falling clock edge, outputs are sampled there too.
module tb_uart_rx;

  localparam int CLK_DIV = 4;
  localparam int BIT_CYC = 16 * CLK_DIV;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       sysclk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic       RX_READ;
  logic [7:0] UART_RXD;
  logic       RX_EFF;
  logic       RX_OVERRUN;
  logic       RX_FRAME_ERR;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of unread bytes plus sticky overrun flag.
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;

  uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .UART_RX     (UART_RX),
    .RX_READ     (RX_READ),
    .UART_RXD    (UART_RXD),
    .RX_EFF      (RX_EFF),
    .RX_OVERRUN  (RX_OVERRUN),
    .RX_FRAME_ERR(RX_FRAME_ERR)
  );

  always #5 sysclk = ~sysclk;

  function automatic void model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
  endfunction

  function automatic void model_read();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_ovr = 1'b0;
  endfunction

  // One 8N1 character, called and returning on a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    UART_RX = 1'b0;
    repeat (BIT_CYC) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BIT_CYC) @(negedge sysclk);
    end
    UART_RX = stop;
    repeat (BIT_CYC) @(negedge sysclk);
    UART_RX = 1'b1;
  endtask

  task automatic do_read();
    RX_READ = 1'b1;
    @(negedge sysclk);
    RX_READ = 1'b0;
    model_read();
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0; UART_RX = 1'b1; RX_READ = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++; if (UART_RXD !== 8'h00) begin errors++; $display("FAIL reset_rxd: got %h expected 00", UART_RXD); end
    checks++; if (RX_EFF !== 1'b0) begin errors++; $display("FAIL reset_eff: got %b expected 0", RX_EFF); end
    checks++; if (RX_OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", RX_OVERRUN); end
    checks++; if (RX_FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", RX_FRAME_ERR); end
    reset = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge sysclk);
      if ({UART_RXD, RX_EFF, RX_OVERRUN, RX_FRAME_ERR} !== 11'd0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_idle: got %0d disturbed cycles expected 0", bad); end
  endtask

  task automatic test_single_byte();
    int lat;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        lat = 0;
        while (RX_EFF !== 1'b1 && lat < 800) begin
          @(negedge sysclk);
          lat++;
        end
      end
    join
    model_push(8'hA5);
    checks++; if (lat < 152 * CLK_DIV + 2 || lat > 152 * CLK_DIV + 4) begin errors++; $display("FAIL single_latency: got %0d expected %0d+-1", lat, 152 * CLK_DIV + 3); end
    checks++; if (RX_EFF !== 1'b1) begin errors++; $display("FAIL single_eff: got %b expected 1", RX_EFF); end
    checks++; if (UART_RXD !== exp_q[0]) begin errors++; $display("FAIL single_data: got %h expected %h", UART_RXD, exp_q[0]); end
    do_read();
    checks++; if (RX_EFF !== 1'b0) begin errors++; $display("FAIL single_pop_eff: got %b expected 0", RX_EFF); end
`ifndef UART_RX_FIFO_EN
    checks++; if (UART_RXD !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h expected a5", UART_RXD); end
`endif
    do_read();
    checks++; if (RX_EFF !== 1'b0) begin errors++; $display("FAIL empty_read_eff: got %b expected 0", RX_EFF); end
  endtask

  task automatic test_random_bytes();
    logic [7:0] b;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_push(b);
      checks++; if (RX_EFF !== 1'b1 || UART_RXD !== exp_q[0]) begin errors++; $display("FAIL random_byte%0d: got eff=%b data=%h expected eff=1 data=%h", n, RX_EFF, UART_RXD, exp_q[0]); end
      do_read();
      checks++; if (RX_EFF !== 1'b0) begin errors++; $display("FAIL random_pop%0d: got %b expected 0", n, RX_EFF); end
    end
  endtask

  task automatic test_glitch();
    int len, ferr;
    for (int n = 0; n < 3; n++) begin
      len = $urandom_range(4, 24);
      UART_RX = 1'b0;
      repeat (len) @(negedge sysclk);
      UART_RX = 1'b1;
      ferr = 0;
      repeat (BIT_CYC * 11) begin
        @(negedge sysclk);
        if (RX_FRAME_ERR || RX_EFF) ferr++;
      end
      checks++; if (ferr !== 0) begin errors++; $display("FAIL glitch%0d_len%0d: got %0d flagged cycles expected 0", n, len, ferr); end
    end
  endtask

  task automatic test_frame_error();
    int pulses, eff_seen;
    fork
      send_frame(8'h3C, 1'b0);
      begin
        pulses = 0; eff_seen = 0;
        repeat (BIT_CYC * 10 + 8) begin
          @(negedge sysclk);
          if (RX_FRAME_ERR) pulses++;
          if (RX_EFF) eff_seen++;
        end
      end
    join
    checks++; if (pulses !== 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", pulses); end
    checks++; if (eff_seen !== 0) begin errors++; $display("FAIL frame_err_nopush: got %0d eff cycles expected 0", eff_seen); end
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    for (int n = 0; n <= DEPTH; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_push(b);
    end
    checks++; if (RX_OVERRUN !== exp_ovr) begin errors++; $display("FAIL overrun_flag: got %b expected %b", RX_OVERRUN, exp_ovr); end
    checks++; if (UART_RXD !== exp_q[0] || RX_EFF !== 1'b1) begin errors++; $display("FAIL overrun_head: got %h expected %h", UART_RXD, exp_q[0]); end
    do_read();
    checks++; if (RX_OVERRUN !== exp_ovr) begin errors++; $display("FAIL overrun_clear: got %b expected %b", RX_OVERRUN, exp_ovr); end
    while (exp_q.size() > 0) begin
      checks++; if (UART_RXD !== exp_q[0] || RX_EFF !== 1'b1) begin errors++; $display("FAIL overrun_drain: got eff=%b data=%h expected %h", RX_EFF, UART_RXD, exp_q[0]); end
      do_read();
    end
    checks++; if (RX_EFF !== 1'b0) begin errors++; $display("FAIL overrun_empty: got %b expected 0", RX_EFF); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    fork
      begin
        send_frame(b1, 1'b1);
        send_frame(b2, 1'b1);
      end
      begin
        repeat (BIT_CYC * 11) @(negedge sysclk);
        model_push(b1);
        checks++; if (UART_RXD !== exp_q[0] || RX_EFF !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h expected %h", UART_RXD, exp_q[0]); end
        do_read();
      end
    join
    model_push(b2);
    checks++; if (UART_RXD !== exp_q[0] || RX_EFF !== 1'b1 || RX_OVERRUN !== exp_ovr) begin errors++; $display("FAIL b2b_second: got %h ovr=%b expected %h ovr=%b", UART_RXD, RX_OVERRUN, exp_q[0], exp_ovr); end
    do_read();
  endtask

  task automatic test_push_pop_full();
    logic [7:0] b, nb;
    for (int n = 0; n < DEPTH; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_push(b);
    end
    nb = 8'($urandom);
    fork
      send_frame(nb, 1'b1);
      begin
        // Stop sample lands on the (152*CLK_DIV+2)th rising edge after the start bit.
        repeat (152 * CLK_DIV + 2) @(negedge sysclk);
        RX_READ = 1'b1;
        @(negedge sysclk);
        RX_READ = 1'b0;
      end
    join
    model_read();
    model_push(nb);
    checks++; if (RX_OVERRUN !== 1'b0) begin errors++; $display("FAIL pushpop_ovr: got %b expected 0", RX_OVERRUN); end
    while (exp_q.size() > 0) begin
      checks++; if (UART_RXD !== exp_q[0] || RX_EFF !== 1'b1) begin errors++; $display("FAIL pushpop_order: got eff=%b data=%h expected %h", RX_EFF, UART_RXD, exp_q[0]); end
      do_read();
    end
    checks++; if (RX_EFF !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b expected 0", RX_EFF); end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] b;
    int bad;
    for (int n = 0; n <= DEPTH; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_push(b);
    end
    b = 8'($urandom);
    UART_RX = 1'b0;
    repeat (BIT_CYC) @(negedge sysclk);
    for (int i = 0; i < 3; i++) begin
      UART_RX = b[i];
      repeat (BIT_CYC) @(negedge sysclk);
    end
    reset = 1'b0;
    UART_RX = 1'b1;
    repeat (3) @(negedge sysclk);
    exp_q.delete();
    exp_ovr = 1'b0;
    checks++; if ({UART_RXD, RX_EFF, RX_OVERRUN, RX_FRAME_ERR} !== 11'd0) begin errors++; $display("FAIL middata_reset: got rxd=%h eff=%b ovr=%b ferr=%b expected all 0", UART_RXD, RX_EFF, RX_OVERRUN, RX_FRAME_ERR); end
    reset = 1'b1;
    bad = 0;
    repeat (BIT_CYC * 10) begin
      @(negedge sysclk);
      if (RX_EFF || RX_FRAME_ERR) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL middata_quiet: got %0d flagged cycles expected 0", bad); end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    model_push(b);
    checks++; if (UART_RXD !== exp_q[0] || RX_EFF !== 1'b1) begin errors++; $display("FAIL middata_recover: got %h expected %h", UART_RXD, exp_q[0]); end
    do_read();
  endtask

  initial begin
    reset = 1'b0; UART_RX = 1'b1; RX_READ = 1'b0;
    @(negedge sysclk);
    test_reset();
    test_single_byte();
    test_random_bytes();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_push_pop_full();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
